apu_irq_arbiter: RTL and testbench

Interrupt source arbiter that sits directly upstream of the core's interrupt controller. It latches rising edges on up to 32 peripheral interrupt lines into a pending register, masks them, and selects the lowest-numbered enabled pending source. It presents that source as a stable, level-held request with id and secure bit, and clears the source's pending bit when the core acknowledges it.

---
 rtl/apu_irq_arbiter_if.sv | 27 ++
 rtl/apu_irq_arbiter.sv | 163 ++++++++++++++++
 tb/tb_apu_irq_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/apu_irq_arbiter_if.sv
// apu_irq_arbiter_if: request/acknowledge handshake between the interrupt
// arbiter and the core's interrupt controller.
//   master (arbiter side):    drives irq_o, irq_id_o, irq_sec_o; samples irq_ack_i, irq_ack_id_i
//   slave  (controller side): samples the request; drives the acknowledge
interface apu_irq_arbiter_if;
  logic       irq_o;
  logic [4:0] irq_id_o;
  logic       irq_sec_o;
  logic       irq_ack_i;
  logic [4:0] irq_ack_id_i;

  modport master (
    output irq_o,
    output irq_id_o,
    output irq_sec_o,
    input  irq_ack_i,
    input  irq_ack_id_i
  );

  modport slave (
    input  irq_o,
    input  irq_id_o,
    input  irq_sec_o,
    output irq_ack_i,
    output irq_ack_id_i
  );
endinterface

// File: rtl/apu_irq_arbiter.sv
// apu_irq_arbiter: latches rising edges on up to 32 interrupt lines into a
// pending register, masks them and presents the lowest-numbered enabled
// pending source to the interrupt controller as a level-held request.
// The pending bit of a source is cleared when the core acknowledges it.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   irq_lines_i       peripheral lines (rising edge sets pending)
//   irq_sec_lines_i   per-line secure attribute
//   mask_we_i/_wdata  mask register write
//   sw_set_i/sw_clr_i software pending set/clear pulses
//   irq_if (master)   request (irq/id/sec) and acknowledge (ack/ack_id)
//   pending_o, mask_o register read-back
//
// Build option: define APU_IRQ_SWTRIG_EN to honour sw_set_i / sw_clr_i;
// otherwise both inputs are ignored.
module apu_irq_arbiter #(
  parameter int unsigned          NUM_IRQ    = 32,
  parameter logic [NUM_IRQ-1:0]   RESET_MASK = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_IRQ-1:0]    irq_lines_i,
  input  logic [NUM_IRQ-1:0]    irq_sec_lines_i,
  input  logic                  mask_we_i,
  input  logic [NUM_IRQ-1:0]    mask_wdata_i,
  input  logic [NUM_IRQ-1:0]    sw_set_i,
  input  logic [NUM_IRQ-1:0]    sw_clr_i,
  apu_irq_arbiter_if.master     irq_if,
  output logic [NUM_IRQ-1:0]    pending_o,
  output logic [NUM_IRQ-1:0]    mask_o
);

  localparam int unsigned ID_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    COOL = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 sec_q, sec_d;
  logic                 irq_q;
  logic [NUM_IRQ-1:0]   lines_q;
  logic [NUM_IRQ-1:0]   pending_q, pending_d;
  logic [NUM_IRQ-1:0]   mask_q;

  logic [NUM_IRQ-1:0]   edge_det;
  logic [NUM_IRQ-1:0]   sw_set_eff;
  logic [NUM_IRQ-1:0]   sw_clr_eff;
  logic [NUM_IRQ-1:0]   ack_clr;
  logic [NUM_IRQ-1:0]   active;
  logic                 cand_valid;
  logic [ID_W-1:0]      cand_id;
  logic                 cand_sec;
  logic                 id_active;

  // Software trigger gating
`ifdef APU_IRQ_SWTRIG_EN
  assign sw_set_eff = sw_set_i;
  assign sw_clr_eff = sw_clr_i;
`else
  logic unused_sw;
  assign unused_sw  = ^{sw_set_i, sw_clr_i};
  assign sw_set_eff = '0;
  assign sw_clr_eff = '0;
`endif

  assign edge_det = irq_lines_i & ~lines_q;
  assign active   = pending_q & mask_q;

  // Ack clears only the bit it names, and only while a request is up
  always_comb begin
    ack_clr = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (irq_if.irq_ack_i && (state_q == REQ) && (irq_if.irq_ack_id_i == ID_W'(i))) begin
        ack_clr[i] = 1'b1;
      end
    end
  end

  // Set beats clear so an edge coinciding with an ack is never lost
  assign pending_d = edge_det | sw_set_eff | (pending_q & ~(sw_clr_eff | ack_clr));

  // Lowest-index enabled pending source, and liveness of the held id
  always_comb begin
    cand_valid = 1'b0;
    cand_id    = '0;
    cand_sec   = 1'b0;
    id_active  = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (active[i] && !cand_valid) begin
        cand_valid = 1'b1;
        cand_id    = ID_W'(i);
        cand_sec   = irq_sec_lines_i[i];
      end
      if (id_q == ID_W'(i)) begin
        id_active = active[i];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    sec_d   = sec_q;
    case (state_q)
      IDLE: begin
        if (cand_valid) begin
          id_d    = cand_id;
          sec_d   = cand_sec;
          state_d = REQ;
        end
      end
      REQ: begin
        if (irq_if.irq_ack_i) begin
          state_d = COOL;
        end else if (!id_active) begin
          state_d = IDLE;
        end
      end
      COOL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      id_q      <= '0;
      sec_q     <= 1'b0;
      irq_q     <= 1'b0;
      lines_q   <= '1;
      pending_q <= '0;
      mask_q    <= RESET_MASK;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      sec_q     <= sec_d;
      irq_q     <= (state_d == REQ);
      lines_q   <= irq_lines_i;
      pending_q <= pending_d;
      if (mask_we_i) begin
        mask_q <= mask_wdata_i;
      end
    end
  end

  assign irq_if.irq_o     = irq_q;
  assign irq_if.irq_id_o  = id_q;
  assign irq_if.irq_sec_o = sec_q;
  assign pending_o        = pending_q;
  assign mask_o           = mask_q;

endmodule

// File: tb/tb_apu_irq_arbiter.sv
// Self-checking bench for apu_irq_arbiter: directed scenarios followed by a
// randomized phase, all compared cycle by cycle against a reference model.
module tb_apu_irq_arbiter;

`ifdef APU_IRQ_SWTRIG_EN
  localparam bit SW_EN = 1'b1;
`else
  localparam bit SW_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] irq_lines;
  logic [31:0] irq_sec_lines;
  logic        mask_we;
  logic [31:0] mask_wdata;
  logic [31:0] sw_set;
  logic [31:0] sw_clr;
  logic [31:0] pending;
  logic [31:0] mask;

  int total = 0;
  int bad   = 0;

  apu_irq_arbiter_if irq_bus ();

  apu_irq_arbiter #(.NUM_IRQ(32), .RESET_MASK(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .irq_lines_i     (irq_lines),
    .irq_sec_lines_i (irq_sec_lines),
    .mask_we_i       (mask_we),
    .mask_wdata_i    (mask_wdata),
    .sw_set_i        (sw_set),
    .sw_clr_i        (sw_clr),
    .irq_if          (irq_bus.master),
    .pending_o       (pending),
    .mask_o          (mask)
  );

  always #5 clk = ~clk;

  // Reference model: which source is being requested, plus a cool-down flag
  logic [31:0] m_prev, m_pend, m_mask;
  logic        m_req, m_cool, m_sec;
  logic [4:0]  m_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic [31:0] act, setv, clrv;
    logic [31:0] n_prev, n_pend, n_mask;
    logic        n_req, n_cool, n_sec;
    logic [4:0]  n_id;
    if (rst) begin
      n_prev = '1; n_pend = '0; n_mask = '0;
      n_req = 1'b0; n_cool = 1'b0; n_sec = 1'b0; n_id = '0;
    end else begin
      act    = m_pend & m_mask;
      n_req  = m_req;
      n_id   = m_id;
      n_sec  = m_sec;
      n_cool = 1'b0;
      if (m_cool) begin
        n_req = 1'b0;
      end else if (m_req) begin
        if (irq_bus.irq_ack_i) begin
          n_req  = 1'b0;
          n_cool = 1'b1;
        end else if (!act[m_id]) begin
          n_req = 1'b0;
        end
      end else begin
        for (int i = 31; i >= 0; i--) begin
          if (act[i]) begin
            n_req = 1'b1;
            n_id  = 5'(i);
            n_sec = irq_sec_lines[i];
          end
        end
      end
      setv = (irq_lines & ~m_prev) | (SW_EN ? sw_set : 32'h0);
      clrv = SW_EN ? sw_clr : 32'h0;
      if (m_req && !m_cool && irq_bus.irq_ack_i) clrv[irq_bus.irq_ack_id_i] = 1'b1;
      n_pend = setv | (m_pend & ~clrv);
      n_mask = mask_we ? mask_wdata : m_mask;
      n_prev = irq_lines;
    end
    @(posedge clk);
    #1;
    m_prev = n_prev; m_pend = n_pend; m_mask = n_mask;
    m_req = n_req; m_cool = n_cool; m_sec = n_sec; m_id = n_id;
    chk("irq",     32'(irq_bus.irq_o),     32'(m_req));
    chk("irq_id",  32'(irq_bus.irq_id_o),  32'(m_id));
    chk("irq_sec", 32'(irq_bus.irq_sec_o), 32'(m_sec));
    chk("pending", pending, m_pend);
    chk("mask",    mask,    m_mask);
  endtask

  task automatic idle_inputs();
    mask_we = 1'b0; sw_set = '0; sw_clr = '0;
    irq_bus.irq_ack_i = 1'b0; irq_bus.irq_ack_id_i = '0;
  endtask

  task automatic ack(input logic [4:0] id);
    irq_bus.irq_ack_i = 1'b1; irq_bus.irq_ack_id_i = id;
    cycle();
    irq_bus.irq_ack_i = 1'b0;
  endtask

  task automatic wmask(input logic [31:0] v);
    mask_we = 1'b1; mask_wdata = v;
    cycle();
    mask_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_lines = 32'h1; irq_sec_lines = 32'h0000_00A8;
    mask_wdata = '0;
    idle_inputs();
    m_prev = '1; m_pend = '0; m_mask = '0;
    m_req = 1'b0; m_cool = 1'b0; m_sec = 1'b0; m_id = '0;
    cycle(); cycle();
    chk("reset_irq", 32'(irq_bus.irq_o), 32'h0);
    chk("reset_pending", pending, 32'h0);
    rst = 1'b0;

    // Line 0 already high at reset release must not fire
    wmask('1);
    repeat (3) cycle();
    chk("quiet_pending", pending, 32'h0);
    chk("quiet_irq", 32'(irq_bus.irq_o), 32'h0);
    irq_lines = '0; cycle();

    // Edge -> request -> ack
    irq_lines = 32'h20; cycle();
    chk("edge_pend5", 32'(pending[5]), 32'h1);
    chk("edge_irq_lat", 32'(irq_bus.irq_o), 32'h0);
    cycle();
    chk("req_irq", 32'(irq_bus.irq_o), 32'h1);
    chk("req_id5", 32'(irq_bus.irq_id_o), 32'd5);
    chk("req_sec5", 32'(irq_bus.irq_sec_o), 32'h1);
    ack(5'd5);
    chk("ack_pend5", 32'(pending[5]), 32'h0);
    chk("ack_irq", 32'(irq_bus.irq_o), 32'h0);
    cycle();
    chk("cool_irq", 32'(irq_bus.irq_o), 32'h0);
    irq_lines = '0; cycle();

    // Priority and stability
    irq_lines = 32'h88; cycle(); cycle();
    chk("prio_id3", 32'(irq_bus.irq_id_o), 32'd3);
    irq_lines = 32'h8A; cycle(); cycle(); cycle();
    chk("stable_id3", 32'(irq_bus.irq_id_o), 32'd3);
    chk("stable_irq", 32'(irq_bus.irq_o), 32'h1);
    ack(5'd3); cycle(); cycle();
    chk("next_id1", 32'(irq_bus.irq_id_o), 32'd1);
    chk("next_irq1", 32'(irq_bus.irq_o), 32'h1);
    ack(5'd1); cycle(); cycle();
    chk("next_id7", 32'(irq_bus.irq_id_o), 32'd7);
    ack(5'd7); cycle();
    irq_lines = '0; cycle();

    // Withdraw on mask-off
    irq_lines = 32'h10; cycle(); cycle();
    chk("wd_req4", 32'(irq_bus.irq_id_o), 32'd4);
    wmask(~32'h10);
    chk("wd_irq_w", 32'(irq_bus.irq_o), 32'h1);
    cycle();
    chk("wd_irq_w1", 32'(irq_bus.irq_o), 32'h0);
    chk("wd_pend4", 32'(pending[4]), 32'h1);
    wmask('1); cycle();
    ack(5'd4); cycle();
    irq_lines = '0; cycle();

    // Ack colliding with a new edge on the same line
    irq_lines = 32'h4; cycle(); cycle();
    irq_lines = 32'h0; cycle();
    irq_lines = 32'h4;
    ack(5'd2);
    chk("coll_pend2", 32'(pending[2]), 32'h1);
    cycle(); cycle();
    chk("coll_rereq", 32'(irq_bus.irq_o), 32'h1);
    chk("coll_id2", 32'(irq_bus.irq_id_o), 32'd2);
    ack(5'd2); cycle();
    irq_lines = '0; cycle();

    // Software set / clear
    sw_set = 32'h100; cycle(); sw_set = '0; cycle();
    chk("sw_irq", 32'(irq_bus.irq_o), 32'(SW_EN));
    chk("sw_pend8", 32'(pending[8]), 32'(SW_EN));
    if (irq_bus.irq_o) begin ack(5'd8); cycle(); end
    sw_set = 32'h200; cycle(); sw_set = '0; cycle();
    sw_clr = 32'h200; cycle(); sw_clr = '0; cycle();
    chk("swclr_irq", 32'(irq_bus.irq_o), 32'h0);
    cycle();

    // Reset during an active request
    irq_lines = 32'h40; cycle(); cycle();
    rst = 1'b1; cycle();
    chk("rst_req_irq", 32'(irq_bus.irq_o), 32'h0);
    chk("rst_req_pend", pending, 32'h0);
    rst = 1'b0; irq_lines = '0; cycle();

    // Randomized phase
    irq_sec_lines = $urandom;
    wmask('1);
    for (int n = 0; n < 600; n++) begin
      irq_lines = irq_lines ^ ($urandom & $urandom & $urandom);
      mask_we = ($urandom_range(15) == 0);
      mask_wdata = $urandom | $urandom;
      sw_set = $urandom & $urandom & $urandom & $urandom;
      sw_clr = $urandom & $urandom & $urandom & $urandom;
      irq_bus.irq_ack_i = 1'b0;
      if (m_req && $urandom_range(2) == 0) begin
        irq_bus.irq_ack_i = 1'b1;
        irq_bus.irq_ack_id_i = ($urandom_range(3) == 0) ? 5'($urandom) : m_id;
      end else if ($urandom_range(15) == 0) begin
        irq_bus.irq_ack_i = 1'b1;
        irq_bus.irq_ack_id_i = 5'($urandom);
      end
      cycle();
    end
    idle_inputs();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
